// File: rtl/bounce_gen.sv
// Emulated bouncy switch: each requested transition is followed by a random
// burst of bounce pairs, then the line holds the target level until settled.
module bounce_gen #(
    parameter int          MAX_BOUNCES = 4,
    parameter int          MIN_HOLD    = 12,
    parameter int          JITTER_W    = 6,
    parameter int          SETTLE_CYC  = 120,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic        INIT_LEVEL  = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       level_i,
    output logic       ready_o,
    output logic       sw_o,
    output logic       done_o,
    output logic [3:0] nbounce_o
);

    localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] JMASK       = 16'((32'd1 << JITTER_W) - 32'd1);
    localparam logic [15:0] HOLD_BASE   = 16'(MIN_HOLD - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);
    localparam logic [3:0]  MAX_N       = 4'(MAX_BOUNCES);

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    // Galois form of x^16+x^14+x^13+x^11+1; a nonzero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    state_t      state_reg;
    logic [15:0] lfsr_reg;
    logic [15:0] cnt_reg;
    logic [4:0]  toggles_reg;
    logic        target_reg;
    logic        sw_reg;
    logic        ready_reg;
    logic        done_reg;
    logic [3:0]  nbounce_reg;

    logic [15:0] lfsr_step1;
    logic [15:0] lfsr_step2;
    logic [3:0]  draw_n;
    logic [15:0] hold_first;
    logic [15:0] hold_next;

    // Counters are loaded with (length - 1) and expire when they reach zero.
    // On acceptance the bounce count is drawn first, then the first phase
    // length from the advanced value, so the LFSR steps twice that cycle.
    always_comb begin
        lfsr_step1 = lfsr_step(lfsr_reg);
        lfsr_step2 = lfsr_step(lfsr_step1);
        draw_n     = (lfsr_reg[3:0] > MAX_N) ? MAX_N : lfsr_reg[3:0];
        hold_first = HOLD_BASE + (lfsr_step1 & JMASK);
        hold_next  = HOLD_BASE + (lfsr_reg & JMASK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            lfsr_reg    <= SEED_EFF;
            cnt_reg     <= 16'd0;
            toggles_reg <= 5'd0;
            target_reg  <= INIT_LEVEL;
            sw_reg      <= INIT_LEVEL;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b0;
            nbounce_reg <= 4'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        ready_reg  <= 1'b0;
                        target_reg <= level_i;
                        cnt_reg    <= SETTLE_LOAD;
                        if (level_i == sw_reg) begin
                            nbounce_reg <= 4'd0;
                            state_reg   <= SETTLE;
                        end else begin
                            sw_reg      <= level_i;
                            nbounce_reg <= draw_n;
                            if (draw_n == 4'd0) begin
                                lfsr_reg  <= lfsr_step1;
                                state_reg <= SETTLE;
                            end else begin
                                lfsr_reg    <= lfsr_step2;
                                cnt_reg     <= hold_first;
                                toggles_reg <= {draw_n, 1'b0};
                                state_reg   <= BOUNCE;
                            end
                        end
                    end
                end
                BOUNCE: begin
                    if (cnt_reg == 16'd0) begin
                        toggles_reg <= toggles_reg - 5'd1;
                        if (toggles_reg == 5'd1) begin
                            sw_reg    <= target_reg;
                            cnt_reg   <= SETTLE_LOAD;
                            state_reg <= SETTLE;
                        end else begin
                            sw_reg   <= ~sw_reg;
                            cnt_reg  <= hold_next;
                            lfsr_reg <= lfsr_step1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_reg == 16'd0) begin
                        done_reg  <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready_o   = ready_reg;
    assign sw_o      = sw_reg;
    assign done_o    = done_reg;
    assign nbounce_o = nbounce_reg;

endmodule
